// File: rtl/if_fetch_redirect.sv
// IF-stage fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake, and produces the ID squash window.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirect targets are reported instead of fetched.
module if_fetch_redirect #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter int unsigned BJ_SQUASH   = 2,
    parameter int unsigned MRET_SQUASH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ex_bj_taken,
    input  logic [31:0] ex_bj_target,
    input  logic        ex_mret,
    input  logic [31:0] csr_mepc,
    input  logic        trap_valid,
    input  logic [31:0] csr_mtvec,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        squash_id,
    output logic        squash_is_mret,
    output logic        redirect_busy
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign,
    output logic [31:0] fetch_misalign_addr
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    localparam logic [1:0] BJ_CNT   = 2'(BJ_SQUASH);
    localparam logic [1:0] MRET_CNT = 2'(MRET_SQUASH);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_mret_q, is_mret_d;
    logic        busy_q, busy_d;

    logic        redir;
    logic        redir_mret;
    logic        redir_bad;
    logic        park_d;
    logic        capture;
    logic [31:0] redir_raw;
    logic [31:0] redir_target;
    state_e      resume_state;

    // Redirect source priority: trap > mret > branch/jump.
    always_comb begin
        redir      = trap_valid | ex_mret | ex_bj_taken;
        redir_mret = trap_valid | ex_mret;
        if (trap_valid) begin
            redir_raw = csr_mtvec;
        end else if (ex_mret) begin
            redir_raw = csr_mepc;
        end else begin
            redir_raw = ex_bj_target;
        end
        redir_target = redir_raw & ~32'h0000_0003;
    end

`ifdef MISALIGN_TRAP_EN
    logic        park_q;
    logic        fetch_misalign_q, fetch_misalign_d;
    logic [31:0] fetch_misalign_addr_q, fetch_misalign_addr_d;

    // A misaligned target parks the fetcher until a trap redirect arrives.
    always_comb begin
        redir_bad             = redir & (redir_raw[1:0] != 2'b00);
        park_d                = trap_valid ? redir_bad : (park_q | redir_bad);
        fetch_misalign_d      = redir_bad;
        fetch_misalign_addr_d = redir_bad ? redir_raw : fetch_misalign_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            park_q                <= 1'b0;
            fetch_misalign_q      <= 1'b0;
            fetch_misalign_addr_q <= 32'h0;
        end else begin
            park_q                <= park_d;
            fetch_misalign_q      <= fetch_misalign_d;
            fetch_misalign_addr_q <= fetch_misalign_addr_d;
        end
    end

    assign fetch_misalign      = fetch_misalign_q;
    assign fetch_misalign_addr = fetch_misalign_addr_q;
`else
    assign redir_bad = 1'b0;
    assign park_d    = 1'b0;
`endif

    // A response in WAIT is only kept when no redirect kills it in the same cycle.
    assign capture = (state_q == WAIT) && imem_rvalid && !redir;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        resume_state = (stall || park_d) ? IDLE : REQ;
        case (state_q)
            IDLE: begin
                if (!stall && !park_d) state_d = REQ;
            end
            REQ: begin
                if (redir) begin
                    state_d = imem_gnt ? DROP : (park_d ? IDLE : REQ);
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = resume_state;
                end else if (redir) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = resume_state;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req       = (state_q == REQ);
        imem_addr      = pc_q;
        if_pc          = if_pc_q;
        if_valid       = if_valid_q;
        squash_id      = (cnt_q != 2'd0);
        squash_is_mret = is_mret_q && (cnt_q != 2'd0);
        if_inst        = (cnt_q != 2'd0) ? NOP_INST : if_inst_q;
        redirect_busy  = busy_q;
    end

    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        cnt_d      = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
        is_mret_d  = is_mret_q;
        busy_d     = busy_q;

        if (capture) begin
            if_valid_d = 1'b1;
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            busy_d     = 1'b0;
        end else if (!stall) begin
            if_valid_d = 1'b0;
        end

        // A held instruction is younger than the redirecting one, so it is turned into a NOP.
        if (redir) begin
            pc_d      = redir_target;
            if_inst_d = NOP_INST;
            cnt_d     = redir_mret ? MRET_CNT : BJ_CNT;
            is_mret_d = redir_mret;
            busy_d    = !redir_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= RESET_PC;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
            cnt_q      <= 2'd0;
            is_mret_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
            is_mret_q  <= is_mret_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed self-checking bench for if_fetch_redirect (default build, default parameters).
module tb_if_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ex_bj_taken;
    logic [31:0] ex_bj_target;
    logic        ex_mret;
    logic [31:0] csr_mepc;
    logic        trap_valid;
    logic [31:0] csr_mtvec;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        squash_id;
    logic        squash_is_mret;
    logic        redirect_busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ex_bj_taken    (ex_bj_taken),
        .ex_bj_target   (ex_bj_target),
        .ex_mret        (ex_mret),
        .csr_mepc       (csr_mepc),
        .trap_valid     (trap_valid),
        .csr_mtvec      (csr_mtvec),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .squash_id      (squash_id),
        .squash_is_mret (squash_is_mret),
        .redirect_busy  (redirect_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1; stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        ex_bj_taken = 1'b0; ex_bj_target = 32'h0; ex_mret = 1'b0; csr_mepc = 32'h0;
        trap_valid = 1'b0; csr_mtvec = 32'h0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
        n_checks++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got=%h exp=%h", if_inst, NOP); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
        n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL rst_squash got=%0b exp=0", squash_id); end
        n_checks++; if (squash_is_mret !== 1'b0) begin n_fail++; $display("FAIL rst_is_mret got=%0b exp=0", squash_is_mret); end
        n_checks++; if (redirect_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", redirect_busy); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_a;
        apply_reset;
        tick;
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'(i) * 32'd4;
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_a) begin n_fail++; $display("FAIL seq_req%0d got=%0b/%h exp=1/%h", i, imem_req, imem_addr, exp_a); end
            imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait%0d got=%0b exp=0", i, imem_req); end
            imem_rvalid = 1'b1; imem_rdata = 32'h1000 + 32'(i); tick; imem_rvalid = 1'b0;
            n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got=%0b exp=1", i, if_valid); end
            n_checks++; if (if_pc !== exp_a) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, if_pc, exp_a); end
            n_checks++; if (if_inst !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL seq_inst%0d got=%h exp=%h", i, if_inst, 32'h1000 + 32'(i)); end
            n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL seq_squash%0d got=%0b exp=0", i, squash_id); end
        end
        tick;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_pulse got=%0b exp=0", if_valid); end
    endtask

    task automatic test_bj_redirect;
        apply_reset;
        tick;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        ex_bj_taken = 1'b1; ex_bj_target = 32'h0000_0102;
        n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL bj_sq_t0 got=%0b exp=0", squash_id); end
        tick; ex_bj_taken = 1'b0;
        n_checks++; if (squash_id !== 1'b1 || squash_is_mret !== 1'b0) begin n_fail++; $display("FAIL bj_sq_t1 got=%0b/%0b exp=1/0", squash_id, squash_is_mret); end
        n_checks++; if (redirect_busy !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bj_drop got=%0b/%0b exp=1/0", redirect_busy, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bj_stale got=%0b exp=0", if_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL bj_addr got=%0b/%h exp=1/00000100", imem_req, imem_addr); end
        n_checks++; if (squash_id !== 1'b1) begin n_fail++; $display("FAIL bj_sq_t2 got=%0b exp=1", squash_id); end
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL bj_sq_t3 got=%0b exp=0", squash_id); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0200; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h200) begin n_fail++; $display("FAIL bj_fetch got=%0b/%h/%h exp=1/00000100/00000200", if_valid, if_pc, if_inst); end
        n_checks++; if (redirect_busy !== 1'b0) begin n_fail++; $display("FAIL bj_busy_clr got=%0b exp=0", redirect_busy); end
    endtask

    task automatic test_mret_priority;
        apply_reset;
        tick;
        ex_mret = 1'b1; csr_mepc = 32'h80; ex_bj_taken = 1'b1; ex_bj_target = 32'h300;
        tick; ex_mret = 1'b0; ex_bj_taken = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL mret_addr got=%0b/%h exp=1/00000080", imem_req, imem_addr); end
        n_checks++; if (squash_id !== 1'b1 || squash_is_mret !== 1'b1) begin n_fail++; $display("FAIL mret_sq_t1 got=%0b/%0b exp=1/1", squash_id, squash_is_mret); end
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        n_checks++; if (squash_id !== 1'b0 || squash_is_mret !== 1'b0) begin n_fail++; $display("FAIL mret_sq_t2 got=%0b/%0b exp=0/0", squash_id, squash_is_mret); end
        imem_rvalid = 1'b1; imem_rdata = 32'h55; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_inst !== 32'h55) begin n_fail++; $display("FAIL mret_fetch got=%0b/%h/%h exp=1/00000080/00000055", if_valid, if_pc, if_inst); end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        tick;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        trap_valid = 1'b1; csr_mtvec = 32'h200;
        tick; trap_valid = 1'b0;
        n_checks++; if (squash_is_mret !== 1'b1 || redirect_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_trap got=%0b/%0b exp=1/1", squash_is_mret, redirect_busy); end
        tick;
        n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL b2b_win1 got=%0b exp=0", squash_id); end
        ex_bj_taken = 1'b1; ex_bj_target = 32'h300;
        tick; ex_bj_taken = 1'b0;
        n_checks++; if (squash_id !== 1'b1 || squash_is_mret !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_reload got=%0b/%0b/%0b exp=1/0/0", squash_id, squash_is_mret, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_stale got=%0b exp=0", if_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_addr got=%0b/%h exp=1/00000300", imem_req, imem_addr); end
        n_checks++; if (squash_id !== 1'b1) begin n_fail++; $display("FAIL b2b_sq2 got=%0b exp=1", squash_id); end
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        n_checks++; if (squash_id !== 1'b0) begin n_fail++; $display("FAIL b2b_sq3 got=%0b exp=0", squash_id); end
        imem_rvalid = 1'b1; imem_rdata = 32'h77; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_inst !== 32'h77) begin n_fail++; $display("FAIL b2b_fetch got=%0b/%h/%h exp=1/00000300/00000077", if_valid, if_pc, if_inst); end
    endtask

    task automatic test_stall;
        apply_reset;
        tick;
        ex_bj_taken = 1'b1; ex_bj_target = 32'h40;
        tick; ex_bj_taken = 1'b0;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234; stall = 1'b1;
        tick; imem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== 32'h1234) begin n_fail++; $display("FAIL stall_hold%0d got=%0b/%h/%h exp=1/00000040/00001234", c, if_valid, if_pc, if_inst); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq%0d got=%0b exp=0", c, imem_req); end
            if (c == 2) stall = 1'b0;
            tick;
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL stall_resume got=%0b/%h exp=1/00000044", imem_req, imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%0b exp=0", if_valid); end
    endtask

    task automatic test_window_nop;
        apply_reset;
        tick;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h99; stall = 1'b1;
        tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_inst !== 32'h99) begin n_fail++; $display("FAIL nop_pre got=%0b/%h exp=1/00000099", if_valid, if_inst); end
        ex_bj_taken = 1'b1; ex_bj_target = 32'h500;
        tick; ex_bj_taken = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_inst !== NOP || squash_id !== 1'b1) begin n_fail++; $display("FAIL nop_window got=%0b/%h/%0b exp=1/%h/1", if_valid, if_inst, squash_id, NOP); end
        stall = 1'b0;
        tick;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500 || if_valid !== 1'b0) begin n_fail++; $display("FAIL nop_resume got=%0b/%h/%0b exp=1/00000500/0", imem_req, imem_addr, if_valid); end
    endtask

    task automatic test_wrap;
        apply_reset;
        tick;
        ex_bj_taken = 1'b1; ex_bj_target = 32'hFFFF_FFFC;
        tick; ex_bj_taken = 1'b0;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'h11; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h11) begin n_fail++; $display("FAIL wrap_fetch got=%0b/%h/%h exp=1/fffffffc/00000011", if_valid, if_pc, if_inst); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got=%0b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch;
        apply_reset;
        tick;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hA; tick; imem_rvalid = 1'b0;
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        rst = 1'b1; tick; rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hEE; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || if_inst !== NOP) begin n_fail++; $display("FAIL rmid_ignore got=%0b/%h exp=0/%h", if_valid, if_inst, NOP); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_addr got=%0b/%h exp=1/00000000", imem_req, imem_addr); end
        imem_gnt = 1'b1; tick; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h42; tick; imem_rvalid = 1'b0;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h42) begin n_fail++; $display("FAIL rmid_fetch got=%0b/%h/%h exp=1/00000000/00000042", if_valid, if_pc, if_inst); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_bj_redirect;
        test_mret_priority;
        test_back_to_back;
        test_stall;
        test_window_nop;
        test_wrap;
        test_reset_mid_fetch;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
